// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one line-wide memory port between NUM_PORTS cache-side requesters.
//   Only one transaction is in flight at a time. The winning request's address,
//   write line and operation are captured at grant, so requesters may change
//   their inputs freely while the transaction runs.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   req_read     per-port read request, held until that port sees req_resp
//   req_write    per-port write request, held until that port sees req_resp
//   req_addr     packed per-port addresses, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata    packed per-port write lines, port p at [p*LINE_W +: LINE_W]
//   req_rdata    read line broadcast to every port (mirrors mem_rdata)
//   req_resp     one-hot completion, asserted only for the granted port
//   mem_read     memory read strobe, high for the whole memory access
//   mem_write    memory write strobe, high for the whole memory access
//   mem_address  captured address of the granted request
//   mem_wdata    captured write line of the granted request
//   mem_rdata    memory read line
//   mem_resp     memory completion pulse
//   grant_id     index of the current or most recent granted port
//   busy         high from grant until the arbiter is back in IDLE
//
// Handshake: a port raises req_read or req_write (write wins if both are high)
// and holds it with stable address/data until req_resp is seen for that port;
// it must drop the request in the following cycle. On the memory side a strobe
// stays high until mem_resp is sampled, then falls in the next cycle.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int RR_MODE   = 1,
    localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [LINE_W-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic [LINE_W-1:0]           mem_rdata,
    input  logic                        mem_resp,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ADDR_W-1:0]    lat_addr;
    logic [LINE_W-1:0]    lat_wdata;
    logic [NUM_PORTS-1:0] req_any;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    int                   idx;

    assign req_any = req_read | req_write;

    // Winner search. In round-robin mode the scan starts at rr_ptr and wraps;
    // in fixed-priority mode it starts at port 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (RR_MODE != 0) idx = int'(rr_ptr) + i;
            else              idx = i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!win_found && req_any[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id  <= win_id;
                        lat_addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[int'(win_id)*LINE_W +: LINE_W];
                        // A port asserting both read and write gets a write.
                        mem_write <= req_write[win_id];
                        mem_read  <= ~req_write[win_id];
                        if (int'(win_id) == NUM_PORTS - 1) rr_ptr <= '0;
                        else                               rr_ptr <= win_id + 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Gives the requester a cycle to drop its request.
                    state <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Completion is combinational so the requester sees it in the same cycle
    // memory responds.
    always_comb begin
        req_resp = '0;
        if (state == BUSY && mem_resp) req_resp[grant_id] = 1'b1;
    end

    assign req_rdata   = mem_rdata;
    assign mem_address = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int LW = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus; instance 0 is round-robin, instance 1 fixed priority
  logic [NP-1:0]    req_read  = '0;
  logic [NP-1:0]    req_write = '0;
  logic [NP*AW-1:0] req_addr  = '0;
  logic [NP*LW-1:0] req_wdata = '0;
  logic [LW-1:0]    mem_rdata = '0;
  logic             mem_resp  = 1'b0;

  logic [LW-1:0] o_rdata [2];
  logic [NP-1:0] o_resp  [2];
  logic          o_rd    [2];
  logic          o_wr    [2];
  logic [AW-1:0] o_addr  [2];
  logic [LW-1:0] o_wdata [2];
  logic [0:0]    o_gid   [2];
  logic          o_busy  [2];

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(o_rdata[0]),
    .req_resp(o_resp[0]), .mem_read(o_rd[0]), .mem_write(o_wr[0]),
    .mem_address(o_addr[0]), .mem_wdata(o_wdata[0]), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .grant_id(o_gid[0]), .busy(o_busy[0])
  );

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(o_rdata[1]),
    .req_resp(o_resp[1]), .mem_read(o_rd[1]), .mem_write(o_wr[1]),
    .mem_address(o_addr[1]), .mem_wdata(o_wdata[1]), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .grant_id(o_gid[1]), .busy(o_busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one transaction at a time. ph = 0 waiting, 1 memory
  // access in progress, 2 one-cycle completion gap. Timing does not depend on
  // the winner, so both instances share ph; only the grant choice differs.
  // ---------------------------------------------------------------------
  int            ph = 0;
  int            m_ptr  [2] = '{0, 0};
  int            m_gid  [2] = '{0, 0};
  logic [AW-1:0] m_addr [2] = '{'0, '0};
  logic [LW-1:0] m_wdata[2] = '{'0, '0};
  bit            m_wr   [2] = '{1'b0, 1'b0};

  function automatic int pick(input logic [NP-1:0] reqs, input int ptr, input bit rr);
    int start = rr ? ptr : 0;
    for (int k = 0; k < NP; k++) begin
      if (reqs[(start + k) % NP]) return (start + k) % NP;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0;
      for (int m = 0; m < 2; m++) begin
        m_ptr[m] <= 0; m_gid[m] <= 0; m_addr[m] <= '0; m_wdata[m] <= '0; m_wr[m] <= 1'b0;
      end
    end else if (ph == 0) begin
      if (|(req_read | req_write)) begin
        ph <= 1;
        for (int m = 0; m < 2; m++) begin
          int g;
          g = pick(req_read | req_write, m_ptr[m], (m == 0));
          m_gid[m]   <= g;
          m_addr[m]  <= req_addr[g*AW +: AW];
          m_wdata[m] <= req_wdata[g*LW +: LW];
          m_wr[m]    <= req_write[g];
          m_ptr[m]   <= (g + 1) % NP;
        end
      end
    end else if (ph == 1) begin
      if (mem_resp) ph <= 2;
    end else begin
      ph <= 0;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        string t;
        logic [NP-1:0] exp_resp;
        t = (m == 0) ? "rr" : "fp";
        exp_resp = (ph == 1 && mem_resp) ? NP'(1 << m_gid[m]) : '0;
        check({t, ".busy"},        LW'(o_busy[m]),  LW'(ph != 0));
        check({t, ".grant_id"},    LW'(o_gid[m]),   LW'(m_gid[m]));
        check({t, ".mem_read"},    LW'(o_rd[m]),    LW'(ph == 1 && !m_wr[m]));
        check({t, ".mem_write"},   LW'(o_wr[m]),    LW'(ph == 1 && m_wr[m]));
        check({t, ".mem_address"}, LW'(o_addr[m]),  LW'(m_addr[m]));
        check({t, ".mem_wdata"},   o_wdata[m],      m_wdata[m]);
        check({t, ".req_rdata"},   o_rdata[m],      mem_rdata);
        check({t, ".req_resp"},    LW'(o_resp[m]),  LW'(exp_resp));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn();
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    req_read = '0;
    req_write = '0;
    step();
  endtask

  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_dead;
  int exp_rr[4] = '{0, 1, 0, 1};

  initial begin
    line_a5   = {8{32'hA5A5_0001}};
    line_dead = {8{32'hDEAD_BEEF}};

    // 1: reset with requests pending
    rst = 1'b1;
    req_read = 2'b11;
    step();
    chk_en = 1'b1;
    step();
    for (int m = 0; m < 2; m++) begin
      check("t1.mem_read", LW'(o_rd[m]), '0);
      check("t1.mem_write", LW'(o_wr[m]), '0);
      check("t1.req_resp", LW'(o_resp[m]), '0);
      check("t1.grant_id", LW'(o_gid[m]), '0);
      check("t1.busy", LW'(o_busy[m]), '0);
    end
    rst = 1'b0;
    req_read = '0;
    step();

    // 2: single read from port 0, memory answers 5 cycles after the request
    req_read = 2'b01;
    req_addr = {32'h0, 32'h0000_1000};
    step();
    check("t2.mem_read", LW'(o_rd[0]), LW'(1'b1));
    check("t2.mem_address", LW'(o_addr[0]), LW'(32'h0000_1000));
    repeat (4) step();
    mem_resp = 1'b1;
    mem_rdata = line_a5;
    #2;
    check("t2.req_resp", LW'(o_resp[0]), LW'(2'b01));
    check("t2.req_rdata", o_rdata[0], line_a5);
    step();
    check("t2.mem_read_low", LW'(o_rd[0]), '0);
    check("t2.busy_done", LW'(o_busy[0]), LW'(1'b1));
    check("t2.resp_in_done", LW'(o_resp[0]), '0);
    mem_resp = 1'b0;
    req_read = '0;
    step();
    check("t2.busy_idle", LW'(o_busy[0]), '0);

    // 3/4: both ports hold reads, 1-cycle memory
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_read = 2'b11;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    for (int t = 0; t < 4; t++) begin
      step();
      check("t3.rr_grant", LW'(o_gid[0]), LW'(exp_rr[t]));
      check("t4.fp_grant", LW'(o_gid[1]), '0);
      mem_resp = 1'b1;
      #2;
      check("t3.rr_resp", LW'(o_resp[0]), LW'(2'b01 << exp_rr[t]));
      check("t4.fp_resp", LW'(o_resp[1]), LW'(2'b01));
      step();
      mem_resp = 1'b0;
      step();
    end
    req_read = 2'b10;
    step();
    check("t4.fp_grant_p1", LW'(o_gid[1]), LW'(1'b1));
    check("t4.fp_addr_p1", LW'(o_addr[1]), LW'(32'h0000_0200));
    finish_txn();

    // 5: port 1 write; inputs change during the access
    req_write = 2'b10;
    req_addr = {32'h0000_2000, 32'h0};
    req_wdata = {line_dead, {LW{1'b0}}};
    step();
    req_addr = {32'h0000_3000, 32'h0};
    req_wdata = {~line_dead, {LW{1'b0}}};
    step();
    step();
    check("t5.mem_address", LW'(o_addr[0]), LW'(32'h0000_2000));
    check("t5.mem_wdata", o_wdata[0], line_dead);
    check("t5.mem_write", LW'(o_wr[0]), LW'(1'b1));
    check("t5.mem_read", LW'(o_rd[0]), '0);
    finish_txn();
    req_read = 2'b10;
    req_write = 2'b10;
    step();
    check("t5.rw_write", LW'(o_wr[1]), LW'(1'b1));
    check("t5.rw_read", LW'(o_rd[1]), '0);
    check("t5.rw_addr", LW'(o_addr[1]), LW'(32'h0000_3000));
    finish_txn();

    // 6: reset mid-transaction, then a late memory response
    req_read = 2'b01;
    step();
    step();
    rst = 1'b1;
    step();
    check("t6.mem_read", LW'(o_rd[0]), '0);
    check("t6.busy", LW'(o_busy[0]), '0);
    check("t6.grant_id", LW'(o_gid[0]), '0);
    rst = 1'b0;
    req_read = '0;
    mem_resp = 1'b1;
    #2;
    check("t6.late_resp", LW'(o_resp[0]), '0);
    step();
    mem_resp = 1'b0;
    check("t6.idle_after_late", LW'(o_busy[0]), '0);
    req_read = 2'b11;
    step();
    check("t6.rr_ptr_reset", LW'(o_gid[0]), '0);
    finish_txn();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
